lms_coeff_updater: RTL and testbench
====================================

Name: lms_coeff_updater

Overview:
Sequencer that applies the LMS weight update c[k] <= c[k] + (mu*e)*x[k] to the coefficient bank feeding the direct-form FIR. One multiplier and one adder are time-shared across all taps, one tap per cycle. The block owns the coefficient registers and drives the FIR's packed coefficient vector. It also provides a host write port for preloading or overriding coefficients while idle.

Parameters:
WIDTH, 16, sample, coefficient, error and step-size word width (signed two's complement)
FRAC, 15, fractional bits of every word (Q(WIDTH-FRAC).FRAC)
TAPS, 2, number of coefficients; legal range is 2 or more

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_start  in  1  one-cycle request to run an update; sampled only in IDLE
i_err  in  WIDTH  error sample e, captured on accepted i_start
i_mu  in  WIDTH  step size mu, captured on accepted i_start
i_x  in  TAPS*WIDTH  packed input vector; x[0] is the current sample and x[k] is delayed k samples; captured on accepted i_start
i_load  in  1  host coefficient write strobe
i_load_idx  in  $clog2(TAPS)  host write index
i_load_data  in  WIDTH  host write data
i_ovr_clr  in  1  clears sticky o_ovr
o_coeffs  out  TAPS*WIDTH  packed coefficient bank, registered, connects directly to the FIR coefficient input
o_busy  out  1  high in SCALE and UPDATE
o_done  out  1  one-cycle pulse when an update completes
o_ovr  out  1  sticky saturation flag
o_miss  out  1  sticky: i_start arrived while not IDLE

Behaviour:
- Reset (asynchronous, i_rstn=0):
  - FSM goes to IDLE.
  - All coefficients = 0.
  - o_busy, o_done, o_ovr and o_miss = 0.
  - Tap counter = 0.
  - A reset mid-update aborts the update immediately. Partially updated coefficients are also cleared.
- FSM states: IDLE, SCALE, UPDATE, DONE.
  - IDLE to SCALE on i_start. In the same cycle, capture e, mu and all TAPS x words into snapshot registers. Later changes on i_err, i_mu and i_x have no effect on the running update.
  - SCALE, 1 cycle: step = sat(floor(mu*e / 2^FRAC)), registered.
  - UPDATE, TAPS cycles: the counter k runs 0..TAPS-1. Each cycle computes c[k] <= sat(c[k] + sat(floor(step*x[k] / 2^FRAC))). The new c[k] is visible on o_coeffs the next cycle. Tap k updates in cycle k, so a tap changes exactly once per run.
  - After k = TAPS-1, go to DONE. DONE lasts 1 cycle with o_done=1, then returns to IDLE.
  - Latency: i_start accepted at cycle 0 gives o_done high at cycle TAPS+2. The next i_start is accepted at TAPS+3 at the earliest.
- Arithmetic:
  - Full-precision signed product of 2*WIDTH bits.
  - Arithmetic right shift by FRAC, i.e. truncation toward negative infinity.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Addition is signed with saturation to the same range.
  - Any saturation event, in the step, a product or a sum, sets o_ovr. o_ovr stays set until i_ovr_clr.
  - If i_ovr_clr and a new saturation occur in the same cycle, the set wins.
- Host load: i_load in IDLE with no i_start writes c[i_load_idx] = i_load_data the next cycle.
  - i_load is ignored outside IDLE.
  - i_load is ignored when i_start is high in the same cycle; start has priority.
  - An index of TAPS or above is ignored.
- o_miss: set when i_start is high in SCALE, UPDATE or DONE. That start is dropped. o_miss is cleared only by reset.
- o_coeffs changes only on an UPDATE cycle or a host write. The FIR sees stable coefficients otherwise.

Test Plan:
1. Reset, then idle -> o_coeffs all 0x0000; o_busy, o_done, o_ovr and o_miss all 0.
2. TAPS=2, mu=0x4000, e=0x2000, x={0x4000,0xC000}, coeffs 0, i_start -> step=0x1000; c0=0x0800 and c1=0xF800; o_done at cycle 4; o_busy high in cycles 1-3; o_ovr stays 0.
3. Preload c0=0x7F00 via i_load, then mu=0x4000, e=0x2000, x0=0x4000 -> c0 saturates to 0x7FFF and o_ovr=1. Then i_ovr_clr -> o_ovr=0.
4. mu=0x8000, e=0x8000 -> step saturates to 0x7FFF and o_ovr=1. Also step=0xFFFF with x=0x4000 -> delta 0xFFFF (floor), so c goes from 0 to 0xFFFF.
5. During UPDATE: pulse i_start, pulse i_load, and change i_x/i_err -> o_miss=1, coefficients match the captured snapshot, the host write is ignored, and o_done timing is unchanged.
6. Assert i_rstn=0 mid-UPDATE -> o_coeffs go to 0 and o_busy to 0 immediately (asynchronous); after release, a new i_start runs normally.

Source files
------------

// File: rtl/lms_coeff_updater.sv
// lms_coeff_updater
// Applies the LMS weight update c[k] <= c[k] + (mu*e)*x[k] to a bank of TAPS
// coefficients. A single multiplier and a single saturating adder are shared
// across the taps, and one tap is updated per cycle. The block owns the
// coefficient registers and drives them straight onto the FIR coefficient bus.
//
// Ports
//   i_clk, i_rstn      clock, asynchronous active-low reset
//   i_start            one-cycle update request, accepted only in IDLE
//   i_err, i_mu, i_x   error, step size and packed x vector (x[0] newest),
//                      all snapshotted on an accepted i_start
//   i_load*            host coefficient write, honoured only in IDLE
//                      when i_start is low
//   i_ovr_clr          clears the sticky saturation flag
//   o_coeffs           packed coefficient bank (registered)
//   o_busy             high in SCALE and UPDATE
//   o_done             one-cycle pulse in DONE
//   o_ovr              sticky: a step, product or sum saturated
//   o_miss             sticky: i_start arrived while not IDLE
module lms_coeff_updater #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 15,
  parameter int TAPS  = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_start,
  input  logic [WIDTH-1:0]            i_err,
  input  logic [WIDTH-1:0]            i_mu,
  input  logic [TAPS*WIDTH-1:0]       i_x,
  input  logic                        i_load,
  input  logic [$clog2(TAPS)-1:0]     i_load_idx,
  input  logic [WIDTH-1:0]            i_load_data,
  input  logic                        i_ovr_clr,
  output logic [TAPS*WIDTH-1:0]       o_coeffs,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_ovr,
  output logic                        o_miss
);

  localparam int IDXW = $clog2(TAPS);
  localparam logic [IDXW-1:0]  K_LAST  = IDXW'(TAPS - 1);
  localparam logic [31:0]      TAPS_U  = 32'(TAPS);
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [2*WIDTH-1:0] WIDE_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] WIDE_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCALE  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Full-precision signed product, floor-shifted by FRAC, saturated to WIDTH.
  // MSB of the result flags a saturation event.
  function automatic logic [WIDTH:0] mul_sat(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shr;
    logic        [WIDTH:0]     res;
    prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    shr  = prod >>> FRAC;
    if (shr > WIDE_MAX) begin
      res = {1'b1, SAT_MAX};
    end else if (shr < WIDE_MIN) begin
      res = {1'b1, SAT_MIN};
    end else begin
      res = {1'b0, shr[WIDTH-1:0]};
    end
    return res;
  endfunction

  // Signed saturating add; MSB of the result flags a saturation event.
  function automatic logic [WIDTH:0] add_sat(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] res;
    sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (sum[WIDTH] != sum[WIDTH-1]) begin
      res = {1'b1, (sum[WIDTH] ? SAT_MIN : SAT_MAX)};
    end else begin
      res = {1'b0, sum[WIDTH-1:0]};
    end
    return res;
  endfunction

  state_t                      state_q, state_d;
  logic [IDXW-1:0]             k_q, k_d;
  logic [WIDTH-1:0]            mu_q, mu_d;
  logic [WIDTH-1:0]            err_q, err_d;
  logic [WIDTH-1:0]            step_q, step_d;
  logic [TAPS-1:0][WIDTH-1:0]  x_q, x_d;
  logic [TAPS-1:0][WIDTH-1:0]  c_q, c_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        ovr_q, ovr_d;
  logic                        miss_q, miss_d;
  logic [WIDTH:0]              step_r_s;
  logic [WIDTH:0]              prod_r_s;
  logic [WIDTH:0]              sum_r_s;
  logic                        sat_s;
  logic                        load_ok_s;

  // Next-state, datapath and flag logic.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    mu_d     = mu_q;
    err_d    = err_q;
    step_d   = step_q;
    x_d      = x_q;
    c_d      = c_q;
    miss_d   = miss_q;
    step_r_s = {(WIDTH+1){1'b0}};
    prod_r_s = {(WIDTH+1){1'b0}};
    sum_r_s  = {(WIDTH+1){1'b0}};
    sat_s    = 1'b0;
    load_ok_s = i_load && (32'(i_load_idx) < TAPS_U);

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          // Snapshot operands so later input changes cannot disturb the run.
          state_d = ST_SCALE;
          mu_d    = i_mu;
          err_d   = i_err;
          x_d     = i_x;
          k_d     = {IDXW{1'b0}};
        end else if (load_ok_s) begin
          c_d[i_load_idx] = i_load_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCALE: begin
        step_r_s = mul_sat(mu_q, err_q);
        step_d   = step_r_s[WIDTH-1:0];
        sat_s    = step_r_s[WIDTH];
        state_d  = ST_UPDATE;
      end
      ST_UPDATE: begin
        prod_r_s = mul_sat(step_q, x_q[k_q]);
        sum_r_s  = add_sat(c_q[k_q], prod_r_s[WIDTH-1:0]);
        c_d[k_q] = sum_r_s[WIDTH-1:0];
        sat_s    = prod_r_s[WIDTH] | sum_r_s[WIDTH];
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (i_start && (state_q != ST_IDLE)) begin
      miss_d = 1'b1;
    end else begin
      miss_d = miss_q;
    end

    // A fresh saturation beats a simultaneous clear.
    if (sat_s) begin
      ovr_d = 1'b1;
    end else if (i_ovr_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    busy_d = (state_d == ST_SCALE) || (state_d == ST_UPDATE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset also clears any partial update.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      k_q     <= {IDXW{1'b0}};
      mu_q    <= {WIDTH{1'b0}};
      err_q   <= {WIDTH{1'b0}};
      step_q  <= {WIDTH{1'b0}};
      x_q     <= {(TAPS*WIDTH){1'b0}};
      c_q     <= {(TAPS*WIDTH){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mu_q    <= mu_d;
      err_q   <= err_d;
      step_q  <= step_d;
      x_q     <= x_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      miss_q  <= miss_d;
    end
  end

  assign o_coeffs = c_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_ovr    = ovr_q;
  assign o_miss   = miss_q;

endmodule

// File: tb/tb_lms_coeff_updater.sv
// Self-checking bench for lms_coeff_updater: directed scenarios plus random
// updates, checked against an integer reference model of the LMS rule.
module tb_lms_coeff_updater;

  localparam int W    = 16;
  localparam int FRAC = 15;
  localparam int TAPS = 3;
  localparam int IDXW = $clog2(TAPS);
  localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (W - 1));

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  start;
  logic [W-1:0]          err;
  logic [W-1:0]          mu;
  logic [TAPS*W-1:0]     x;
  logic                  load;
  logic [IDXW-1:0]       load_idx;
  logic [W-1:0]          load_data;
  logic                  ovr_clr;
  logic [TAPS*W-1:0]     coeffs;
  logic                  busy;
  logic                  done;
  logic                  ovr;
  logic                  miss;

  int total = 0;
  int bad   = 0;

  longint m_c[TAPS];
  longint m_x[TAPS];
  bit     m_ovr;
  bit     m_miss;
  bit     m_sat;

  always #5 clk = ~clk;

  lms_coeff_updater #(.WIDTH(W), .FRAC(FRAC), .TAPS(TAPS)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_err(err), .i_mu(mu),
    .i_x(x), .i_load(load), .i_load_idx(load_idx), .i_load_data(load_data),
    .i_ovr_clr(ovr_clr), .o_coeffs(coeffs), .o_busy(busy), .o_done(done),
    .o_ovr(ovr), .o_miss(miss)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] w);
    return longint'($signed(w));
  endfunction

  function automatic longint sat_w(input longint v);
    if (v > MAXV) begin
      m_sat = 1'b1;
      return MAXV;
    end
    if (v < MINV) begin
      m_sat = 1'b1;
      return MINV;
    end
    return v;
  endfunction

  function automatic logic [TAPS*W-1:0] exp_coeffs();
    logic [TAPS*W-1:0] v;
    for (int k = 0; k < TAPS; k++) v[k*W +: W] = W'(m_c[k]);
    return v;
  endfunction

  // Reference LMS update: floor-scaled products, saturating everywhere.
  task automatic model_update(input logic [W-1:0] mu_v, input logic [W-1:0] e_v);
    longint step;
    longint d;
    m_sat = 1'b0;
    step = sat_w((sx(mu_v) * sx(e_v)) >>> FRAC);
    for (int k = 0; k < TAPS; k++) begin
      d = sat_w((step * m_x[k]) >>> FRAC);
      m_c[k] = sat_w(m_c[k] + d);
    end
    if (m_sat) m_ovr = 1'b1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) m_c[k] = 0;
    m_ovr  = 1'b0;
    m_miss = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_coeffs"}, coeffs, exp_coeffs());
    check_val({tag, "_ovr"}, ovr, m_ovr);
    check_val({tag, "_miss"}, miss, m_miss);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_done"}, done, 1'b0);
  endtask

  task automatic host_load(input logic [IDXW-1:0] idx, input logic [W-1:0] data);
    @(negedge clk);
    load = 1'b1; load_idx = idx; load_data = data;
    @(negedge clk);
    load = 1'b0;
    if (int'(idx) < TAPS) m_c[idx] = sx(data);
    check_val("host_load", coeffs, exp_coeffs());
  endtask

  // One full update; a simultaneous i_load on the start cycle must be ignored.
  // With disturb set, start/load/operand changes are injected mid-UPDATE.
  task automatic run_update(input string tag, input logic [W-1:0] mu_v,
                            input logic [W-1:0] e_v, input bit disturb);
    @(negedge clk);
    mu = mu_v; err = e_v; start = 1'b1;
    for (int k = 0; k < TAPS; k++) x[k*W +: W] = W'(m_x[k]);
    load = 1'b1; load_idx = '0; load_data = 16'h5A5A;
    model_update(mu_v, e_v);
    for (int c = 1; c <= TAPS + 2; c++) begin
      @(negedge clk);
      start = 1'b0; load = 1'b0;
      if (disturb && c == 2) begin
        start = 1'b1; load = 1'b1; load_idx = '0; load_data = 16'h1234;
        x = {TAPS{W'($urandom)}}; err = W'($urandom); mu = W'($urandom);
        m_miss = 1'b1;
      end
      check_val({tag, "_busy"}, busy, (c <= TAPS + 1));
      check_val({tag, "_done"}, done, (c == TAPS + 2));
    end
    @(negedge clk);
    check_idle(tag);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; err = '0; mu = '0; x = '0;
    load = 1'b0; load_idx = '0; load_data = '0; ovr_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // 1: reset state
    check_idle("reset");

    // 2: basic update
    m_x[0] = 16'h4000; m_x[1] = sx(16'hC000); m_x[2] = 0;
    run_update("basic", 16'h4000, 16'h2000, 1'b0);
    check_val("basic_c0", coeffs[15:0], 16'h0800);
    check_val("basic_c1", coeffs[31:16], 16'hF800);

    // 3: coefficient sum saturation, then flag clear
    host_load(2'd0, 16'h7F00);
    host_load(2'd1, 16'h0000);
    host_load(2'd3, 16'hBEEF);
    m_x[0] = 16'h4000; m_x[1] = 0; m_x[2] = 0;
    run_update("sumsat", 16'h4000, 16'h2000, 1'b0);
    check_val("sumsat_c0", coeffs[15:0], 16'h7FFF);
    check_val("sumsat_ovr", ovr, 1'b1);
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0; m_ovr = 1'b0;
    check_val("ovr_clr", ovr, 1'b0);

    // 4: step saturation, then floor on a negative product
    do_reset();
    run_update("stepsat", 16'h8000, 16'h8000, 1'b0);
    check_val("stepsat_c0", coeffs[15:0], 16'h3FFF);
    check_val("stepsat_ovr", ovr, 1'b1);
    do_reset();
    run_update("floor", 16'hFFFF, 16'h7FFF, 1'b0);
    check_val("floor_c0", coeffs[15:0], 16'hFFFF);

    // 5: disturbance during UPDATE
    for (int k = 0; k < TAPS; k++) m_x[k] = sx(W'($urandom));
    run_update("disturb", W'($urandom), W'($urandom), 1'b1);
    check_val("disturb_miss", miss, 1'b1);

    // 6: asynchronous reset in the middle of UPDATE
    host_load(2'd2, 16'h1111);
    m_x[0] = 16'h4000; m_x[1] = 16'h4000; m_x[2] = 16'h4000;
    @(negedge clk);
    mu = 16'h4000; err = 16'h2000; start = 1'b1;
    for (int k = 0; k < TAPS; k++) x[k*W +: W] = W'(m_x[k]);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    model_reset();
    check_val("arst_coeffs", coeffs, '0);
    check_val("arst_busy", busy, 1'b0);
    check_val("arst_miss", miss, 1'b0);
    @(negedge clk); rstn = 1'b1;
    run_update("after_rst", 16'h4000, 16'h2000, 1'b0);

    // random updates with occasional host writes and flag clears
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(3) == 0) host_load(IDXW'($urandom_range(TAPS)), W'($urandom));
      for (int k = 0; k < TAPS; k++) m_x[k] = sx(W'($urandom));
      run_update("rand", W'($urandom), W'($urandom), ($urandom_range(7) == 0));
      if ($urandom_range(2) == 0) begin
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0; m_ovr = 1'b0;
        check_val("rand_clr", ovr, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
